bfp16_add_arbiter: RTL and testbench

Shares one combinational bfp16 adder among NUM_REQ requesters. Arbitration is round-robin with valid/ready handshakes, and each result comes back through a fixed-latency pipeline tagged with the requester id. It sits between the matmul accumulation lanes and a single bfp16 adder instance. The adder's operands are driven from registers and its output is captured into the pipeline. A flush sequencer drains in-flight work on request.

---
 rtl/bfp16_add_arbiter.sv | 151 +++++++++++++++
 tb/tb_bfp16_add_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp16_add_arbiter.sv
// Round-robin arbiter sharing one combinational bfp16 adder, fixed-latency tagged results.
// Optional perf counters (perf_ops, perf_stall) when BFP16_ARB_PERF_EN is defined.
module bfp16_add_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int PIPE_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic [15:0]             add_a,
    output logic [15:0]             add_b,
    input  logic [15:0]             add_o,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             rsp_sum,
    input  logic                    flush_req,
    output logic                    flush_done
`ifdef BFP16_ARB_PERF_EN
    ,
    output logic [31:0]             perf_ops,
    output logic [31:0]             perf_stall
`endif
);

    localparam int LAST = PIPE_LAT - 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt;
    logic            found;
    logic            advance;
    logic            grant_en;
    logic            hs;
    logic            drained;

    logic            s0_valid;
    logic [15:0]     s0_a;
    logic [15:0]     s0_b;
    logic [ID_W-1:0] s0_id;

    logic            st_v   [1:LAST];
    logic [ID_W-1:0] st_id  [1:LAST];
    logic [15:0]     st_sum [1:LAST];

    assign rsp_valid = st_v[LAST];
    assign rsp_id    = st_id[LAST];
    assign rsp_sum   = st_sum[LAST];
    assign add_a     = s0_a;
    assign add_b     = s0_b;

    assign advance  = !(rsp_valid && !rsp_ready);
    assign grant_en = (state == RUN) && !flush_req;
    assign hs       = advance && grant_en && found;

    // Search starts just after the last grant; ptr < NUM_REQ so one wrap suffices.
    always_comb begin
        int idx;
        found = 1'b0;
        gnt   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = ID_W'(idx);
            end
        end
    end

    assign req_ready = hs ? (NUM_REQ'(1) << gnt) : '0;

    always_comb begin
        drained = !s0_valid;
        for (int i = 1; i <= LAST; i++) begin
            if (st_v[i]) drained = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= ID_W'(NUM_REQ - 1);
            s0_valid   <= 1'b0;
            s0_a       <= '0;
            s0_b       <= '0;
            s0_id      <= '0;
            state      <= RUN;
            flush_done <= 1'b0;
            for (int i = 1; i <= LAST; i++) begin
                st_v[i]   <= 1'b0;
                st_id[i]  <= '0;
                st_sum[i] <= '0;
            end
        end else begin
            if (advance) begin
                s0_valid <= hs;
                if (hs) begin
                    s0_a  <= req_a[16*gnt +: 16];
                    s0_b  <= req_b[16*gnt +: 16];
                    s0_id <= gnt;
                    ptr   <= gnt;
                end
                st_v[1]   <= s0_valid;
                st_id[1]  <= s0_id;
                st_sum[1] <= add_o;
                for (int i = 2; i <= LAST; i++) begin
                    st_v[i]   <= st_v[i-1];
                    st_id[i]  <= st_id[i-1];
                    st_sum[i] <= st_sum[i-1];
                end
            end
            unique case (state)
                RUN: begin
                    if (flush_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (drained) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    flush_done <= 1'b0;
                    state      <= flush_req ? DRAIN : RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BFP16_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (hs && perf_ops != 32'hFFFF_FFFF)
                perf_ops <= perf_ops + 32'd1;
            if (!advance && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bfp16_add_arbiter.sv
// Bench for bfp16_add_arbiter: behavioural model compared every cycle plus directed cases.
// Build with BFP16_ARB_PERF_EN to also cover perf counters.
module tb_bfp16_add_arbiter;

    localparam int N = 4;
    localparam int W = 2;
    localparam int L = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic [15:0]     add_a;
    logic [15:0]     add_b;
    logic [15:0]     add_o;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_id;
    logic [15:0]     rsp_sum;
    logic            flush_req;
    logic            flush_done;
`ifdef BFP16_ARB_PERF_EN
    logic [31:0]     perf_ops;
    logic [31:0]     perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    bfp16_add_arbiter #(.NUM_REQ(N), .ID_W(W), .PIPE_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_o(add_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .flush_req(flush_req), .flush_done(flush_done)
`ifdef BFP16_ARB_PERF_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating bfp16 adder for positive normal operands; zero passes through.
    function automatic logic [15:0] bf_add(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a, b;
        logic [7:0]  d, ma, mb;
        logic [8:0]  s;
        if (x[14:0] == 15'd0) return y;
        if (y[14:0] == 15'd0) return x;
        if (x[14:7] >= y[14:7]) begin a = x; b = y; end
        else begin a = y; b = x; end
        d  = a[14:7] - b[14:7];
        ma = {1'b1, a[6:0]};
        mb = (d > 8'd7) ? 8'd0 : ({1'b1, b[6:0]} >> d);
        s  = {1'b0, ma} + {1'b0, mb};
        if (s[8]) return {a[15], a[14:7] + 8'd1, s[7:1]};
        return {a[15], a[14:7], s[6:0]};
    endfunction

    assign add_o = bf_add(add_a, add_b);

    function automatic logic [15:0] rnd_bf();
        return {1'b0, 8'($urandom_range(100, 150)), 7'($urandom)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_ptr;
    int           m_st;      // 0 run, 1 drain, 2 done
    logic         m_s0v;
    logic [15:0]  m_a, m_b;
    logic [W-1:0] m_id;
    logic         mp_v   [1:L-1];
    logic [W-1:0] mp_id  [1:L-1];
    logic [15:0]  mp_sum [1:L-1];
    longint       m_ops, m_stall;

    task automatic model_reset();
        m_ptr = N - 1; m_st = 0; m_s0v = 0;
        m_a = 0; m_b = 0; m_id = 0;
        m_ops = 0; m_stall = 0;
        for (int i = 1; i < L; i++) begin
            mp_v[i] = 0; mp_id[i] = 0; mp_sum[i] = 0;
        end
    endtask

    initial begin
        logic ev, adv, gen, found, hs, empty;
        int g;
        logic [N-1:0] exp_rdy;
        model_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            ev  = mp_v[L-1];
            adv = !(ev && !rsp_ready);
            gen = (m_st == 0) && !flush_req;
            found = 0; g = 0;
            for (int k = 1; k <= N; k++) begin
                int ix;
                ix = (m_ptr + k) % N;
                if (!found && req_valid[ix]) begin found = 1; g = ix; end
            end
            hs = adv && gen && found;
            exp_rdy = hs ? N'(1 << g) : '0;
            chk("req_ready", req_ready, exp_rdy);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_id", rsp_id, mp_id[L-1]);
                chk("rsp_sum", rsp_sum, mp_sum[L-1]);
            end
            chk("add_a", add_a, m_a);
            chk("add_b", add_b, m_b);
            chk("flush_done", flush_done, m_st == 2);
`ifdef BFP16_ARB_PERF_EN
            chk("perf_ops", perf_ops, m_ops);
            chk("perf_stall", perf_stall, m_stall);
`endif
            if (rst) begin
                model_reset();
            end else begin
                empty = !m_s0v;
                for (int i = 1; i < L; i++) if (mp_v[i]) empty = 0;
                if (hs) m_ops = m_ops + 1;
                if (!adv) m_stall = m_stall + 1;
                if (adv) begin
                    for (int i = L - 1; i >= 2; i--) begin
                        mp_v[i] = mp_v[i-1]; mp_id[i] = mp_id[i-1]; mp_sum[i] = mp_sum[i-1];
                    end
                    mp_v[1] = m_s0v; mp_id[1] = m_id; mp_sum[1] = bf_add(m_a, m_b);
                    m_s0v = hs;
                    if (hs) begin
                        m_a = req_a[16*g +: 16]; m_b = req_b[16*g +: 16];
                        m_id = W'(g); m_ptr = g;
                    end
                end
                case (m_st)
                    0: if (flush_req) m_st = 1;
                    1: if (empty) m_st = 2;
                    default: m_st = flush_req ? 1 : 0;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; req_valid = 0; flush_req = 0; rsp_ready = 1;
        nxt(); nxt();
        rst = 0;
    endtask

    task automatic set_ops();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = rnd_bf();
            req_b[16*i +: 16] = rnd_bf();
        end
    endtask

    initial begin
        int ord [6] = '{0, 1, 2, 3, 0, 1};
        int nrsp, got;
        req_a = '0; req_b = '0;
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_flush_done", flush_done, 0);
        nxt();

        // single op from requester 2
        req_valid = 4'b0100;
        req_a[32 +: 16] = 16'h3F80; req_b[32 +: 16] = 16'h3F80;
        @(negedge clk); chk("single_grant", req_ready, 4'b0100);
        nxt(); req_valid = 0;
        nxt();
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, 2);
        chk("single_rsp_sum", rsp_sum, 16'h4000);
        nxt();

        // fairness from reset
        do_reset();
        set_ops();
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 6) chk("fair_grant", req_ready, 1 << ord[i]);
            if (i >= 2) chk("fair_rsp_id", rsp_id, ord[i-2]);
            nxt();
        end
        req_valid = 0;
        repeat (3) nxt();

        // backpressure
        do_reset();
        req_valid = 4'b0001;
        req_a[0 +: 16] = 16'h3F80; req_b[0 +: 16] = 16'h4000;
        nxt();
        req_valid = 4'b0010;
        req_a[16 +: 16] = 16'h3F00; req_b[16 +: 16] = 16'h3F80;
        nxt();
        req_valid = 4'b0100; rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_sum_stable", rsp_sum, 16'h4040);
            chk("bp_req_ready", req_ready, 0);
            nxt();
        end
        rsp_ready = 1; req_valid = 0;
        @(negedge clk); chk("bp_first_sum", rsp_sum, 16'h4040);
        nxt();
        @(negedge clk);
        chk("bp_second_valid", rsp_valid, 1);
        chk("bp_second_sum", rsp_sum, 16'h3FC0);
        chk("bp_second_id", rsp_id, 1);
        nxt();
        repeat (2) nxt();

        // flush
        do_reset();
        set_ops();
        nrsp = 0; got = 0;
        req_valid = 4'b0111;
        repeat (3) begin
            @(negedge clk); if (rsp_valid) nrsp++;
            nxt();
        end
        flush_req = 1;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
            chk("flush_no_grant", req_ready, 0);
            if (flush_done) got = 1;
            nxt();
            flush_req = 0;
        end
        chk("flush_done_seen", got, 1);
        chk("flush_rsp_cnt", nrsp, 3);
        @(negedge clk);
        chk("flush_single_pulse", flush_done, 0);
        chk("flush_resume", req_ready, 4'b0001);
        nxt();
        req_valid = 0;
        repeat (3) nxt();

        // reset with two ops in flight
        req_valid = 4'b0010; nxt();
        req_valid = 4'b1000; nxt();
        req_valid = 0; rsp_ready = 0; rst = 1;
        @(negedge clk); chk("midrst_pre_valid", rsp_valid, 1);
        nxt();
        rst = 0; rsp_ready = 1;
        repeat (4) begin
            @(negedge clk); chk("midrst_no_rsp", rsp_valid, 0);
            nxt();
        end
        req_valid = 4'hF;
        @(negedge clk); chk("midrst_first_grant", req_ready, 4'b0001);
        nxt();
        req_valid = 0;
        repeat (3) nxt();

`ifdef BFP16_ARB_PERF_EN
        do_reset();
        set_ops();
        req_valid = 4'b0001; nrsp = 0;
        for (int i = 0; i < 30 && nrsp < 10; i++) begin
            @(negedge clk); if (req_ready[0]) nrsp++;
            nxt();
        end
        req_valid = 0; rsp_ready = 0;
        repeat (3) nxt();
        rsp_ready = 1;
        repeat (4) nxt();
        @(negedge clk);
        chk("perf_ops_10", perf_ops, 10);
        chk("perf_stall_3", perf_stall, 3);
        nxt();
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_ops();
            req_valid = N'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            flush_req = ($urandom % 48) == 0;
            nxt();
        end
        req_valid = 0; flush_req = 0; rsp_ready = 1;
        repeat (10) nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
